// File: rtl/frame_pkg.sv
// Shared definitions for the frame streamer: default geometry, sizing helpers
// and the sequencer state encoding.
package frame_pkg;

  localparam int unsigned DefaultWidth = 361;
  localparam int unsigned DefaultDepth = 410;
  localparam int unsigned DefaultPixW  = 8;

  // Per-frame phases, in the order a frame walks through them.
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    PROCESS,
    FLUSH
  } frame_state_t;

  // Pixel count of one frame.
  function automatic int unsigned frame_pixels(input int unsigned width,
                                               input int unsigned depth);
    return width * depth;
  endfunction

  // Smallest address width that can index every pixel of an n-pixel frame.
  function automatic int unsigned frame_addr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_addr_counter.sv
// Saturating address counter with synchronous clear. The counter stops at
// LAST and flags it, so callers can compare against the last index without
// ever wrapping.
module frame_addr_counter #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned LAST   = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] count_o,
  output logic              tc_o
);

  localparam logic [ADDR_W-1:0] LastVal = ADDR_W'(LAST);

  logic [ADDR_W-1:0] count_q, count_d;
  logic              tc;

  assign tc = (count_q == LastVal);

  // Next count: clear has priority, increment holds once the last index is reached.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !tc) begin
      count_d = count_q + ADDR_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc;

endmodule

// File: rtl/frame_streamer.sv
// Frame sequencer: clears the filter, loads one frame from the pixel ROM,
// clocks the filter through processing and captures each result into the
// result RAM. All strobes come straight from flops.
module frame_streamer
  import frame_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned DEPTH  = DefaultDepth,
  parameter int unsigned PIX_W  = DefaultPixW,
  parameter int unsigned ADDR_W = frame_addr_w(frame_pixels(WIDTH, DEPTH))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_data,
  output logic              consumer_clr,
  output logic [PIX_W-1:0]  image_input,
  output logic              enable,
  output logic              enable_process,
  input  logic [PIX_W-1:0]  image_output,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NPix    = frame_pixels(WIDTH, DEPTH);
  localparam int unsigned LastIdx = NPix - 1;

  frame_state_t state_q, state_d;

  logic consumer_clr_q, consumer_clr_d;
  logic enable_q, enable_d;
  logic enable_process_q, enable_process_d;
  logic wr_en_q, wr_en_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  // Set in the cycle after the final ROM address went out: that cycle carries
  // the last pixel of the frame.
  logic last_issue_q, last_issue_d;

  logic              rd_clr, rd_inc, rd_tc;
  logic [ADDR_W-1:0] rd_count;
  logic              proc_clr, proc_inc, proc_tc;
  logic [ADDR_W-1:0] proc_count;
  logic              wr_clr, wr_inc, wr_tc;
  logic [ADDR_W-1:0] wr_count;

  // Only the terminal flags of these two counters steer the sequencer.
  logic unused_cnt;
  assign unused_cnt = ^{proc_count, wr_tc};

  // Counter controls derived from the current phase.
  always_comb begin
    // The read address is issued from CLEAR onwards and parked at 0 between frames.
    rd_clr   = (state_q == IDLE) || (state_q == FLUSH);
    rd_inc   = (state_q == CLEAR) || (state_q == LOAD);
    proc_clr = (state_q != PROCESS);
    proc_inc = (state_q == PROCESS);
    // Clearing in FLUSH lands after the last write has been presented.
    wr_clr   = (state_q == IDLE) || (state_q == FLUSH);
    wr_inc   = wr_en_q;
  end

  frame_addr_counter #(
    .ADDR_W (ADDR_W),
    .LAST   (LastIdx)
  ) u_rd_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (rd_clr),
    .inc_i   (rd_inc),
    .count_o (rd_count),
    .tc_o    (rd_tc)
  );

  frame_addr_counter #(
    .ADDR_W (ADDR_W),
    .LAST   (LastIdx)
  ) u_proc_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (proc_clr),
    .inc_i   (proc_inc),
    .count_o (proc_count),
    .tc_o    (proc_tc)
  );

  frame_addr_counter #(
    .ADDR_W (ADDR_W),
    .LAST   (LastIdx)
  ) u_wr_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (wr_clr),
    .inc_i   (wr_inc),
    .count_o (wr_count),
    .tc_o    (wr_tc)
  );

  // Next phase and the strobes that phase will present, so every strobe is a flop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = LOAD;
      LOAD:    if (last_issue_q) state_d = PROCESS;
      PROCESS: if (proc_tc) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    last_issue_d     = ((state_q == CLEAR) || (state_q == LOAD)) && rd_tc;
    consumer_clr_d   = (state_d == CLEAR);
    enable_d         = (state_d == LOAD);
    enable_process_d = (state_d == PROCESS);
    // The filter result trails its process strobe by one cycle.
    wr_en_d          = enable_process_q;
    busy_d           = (state_d != IDLE);
    done_d           = (state_q == FLUSH);
  end

  // Sequencer state and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      last_issue_q     <= 1'b0;
      consumer_clr_q   <= 1'b0;
      enable_q         <= 1'b0;
      enable_process_q <= 1'b0;
      wr_en_q          <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_issue_q     <= last_issue_d;
      consumer_clr_q   <= consumer_clr_d;
      enable_q         <= enable_d;
      enable_process_q <= enable_process_d;
      wr_en_q          <= wr_en_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign mem_addr       = rd_count;
  assign image_input    = mem_data;
  assign consumer_clr   = consumer_clr_q;
  assign enable         = enable_q;
  assign enable_process = enable_process_q;
  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_count;
  assign wr_data        = image_output;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench for frame_streamer on a 4x3 frame, with a synchronous ROM
// model and a frame-buffered saturating-add filter model.
module tb_frame_streamer;

  localparam int unsigned W  = 4;
  localparam int unsigned D  = 3;
  localparam int unsigned N  = W * D;
  localparam int unsigned AW = 4;
  localparam int unsigned PW = 8;

  typedef struct {
    int unsigned cyc;
    int unsigned addr;
    int unsigned data;
  } ev_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_data;
  logic          consumer_clr;
  logic [PW-1:0] image_input;
  logic          enable;
  logic          enable_process;
  logic [PW-1:0] image_output;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic          busy;
  logic          done;

  int unsigned total;
  int unsigned bad;
  int unsigned edge_cnt;
  int unsigned done_cnt;
  int          rom_mode;
  logic [7:0]  add_val;

  ev_t q_clr[$];
  ev_t q_en[$];
  ev_t q_proc[$];
  ev_t q_wr[$];
  ev_t q_done[$];

  frame_streamer #(
    .WIDTH  (W),
    .DEPTH  (D),
    .PIX_W  (PW),
    .ADDR_W (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .consumer_clr   (consumer_clr),
    .image_input    (image_input),
    .enable         (enable),
    .enable_process (enable_process),
    .image_output   (image_output),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .busy           (busy),
    .done           (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] rom_val(input int mode, input int i);
    if (mode == 0) return 8'(i + 10);
    return 8'hF0;
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'(a) + int'(b);
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d, required %0d", name, edge_cnt, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s at edge %0d: got strobe, required none", name, edge_cnt);
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Synchronous pixel ROM.
  initial mem_data = '0;
  always @(posedge clk) mem_data <= rom_val(rom_mode, int'(mem_addr));

  // Frame-buffered filter: loads on enable, returns buf+add one cycle after enable_process.
  logic [7:0] cbuf[N];
  int unsigned li, pi;
  initial image_output = '0;
  always @(posedge clk) begin
    if (consumer_clr) begin
      li = 0;
      pi = 0;
    end
    if (enable && li < N) begin
      cbuf[li] = image_input;
      li++;
    end
    if (enable_process && pi < N) begin
      image_output <= sat_add(cbuf[pi], add_val);
      pi++;
    end
  end

  // Expected events for a frame whose start is sampled at edge s, up to cycle upto.
  task automatic push_frame(input int unsigned s, input int mode, input logic [7:0] add,
                            input int unsigned upto);
    for (int unsigned k = 1; k <= 2 * N + 3 && k <= upto; k++) begin
      ev_t e;
      e.cyc  = s + k - 1;
      e.addr = 0;
      e.data = 0;
      if (k == 1) begin
        q_clr.push_back(e);
      end else if (k <= N + 1) begin
        e.addr = (k - 1 < N - 1) ? k - 1 : N - 1;
        e.data = rom_val(mode, int'(k - 2));
        q_en.push_back(e);
      end
      if (k >= N + 2 && k <= 2 * N + 1) q_proc.push_back(e);
      if (k >= N + 3 && k <= 2 * N + 2) begin
        e.addr = k - (N + 3);
        e.data = sat_add(rom_val(mode, int'(k - (N + 3))), add);
        q_wr.push_back(e);
      end
      if (k == 2 * N + 3) q_done.push_back(e);
    end
  endtask

  // Monitor: every presented strobe pops and checks its expected entry.
  always @(negedge clk) begin
    ev_t e;
    if (enable && enable_process) unexpected("en_and_proc");
    if (consumer_clr) begin
      if (q_clr.size() == 0) unexpected("clr");
      else begin
        e = q_clr.pop_front();
        check("clr_cycle", edge_cnt, e.cyc);
        check("clr_busy", 32'(busy), 1);
      end
    end
    if (enable) begin
      if (q_en.size() == 0) unexpected("enable");
      else begin
        e = q_en.pop_front();
        check("en_cycle", edge_cnt, e.cyc);
        check("en_mem_addr", 32'(mem_addr), e.addr);
        check("en_pixel", 32'(image_input), e.data);
      end
    end
    if (enable_process) begin
      if (q_proc.size() == 0) unexpected("enable_process");
      else begin
        e = q_proc.pop_front();
        check("proc_cycle", edge_cnt, e.cyc);
      end
    end
    if (wr_en) begin
      if (q_wr.size() == 0) unexpected("wr_en");
      else begin
        e = q_wr.pop_front();
        check("wr_cycle", edge_cnt, e.cyc);
        check("wr_addr", 32'(wr_addr), e.addr);
        check("wr_data", 32'(wr_data), e.data);
      end
    end
    if (done) begin
      done_cnt++;
      if (q_done.size() == 0) unexpected("done");
      else begin
        e = q_done.pop_front();
        check("done_cycle", edge_cnt, e.cyc);
        check("done_busy", 32'(busy), 0);
      end
    end
  end

  task automatic issue_start(output int unsigned s);
    start = 1'b1;
    s = edge_cnt + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    int unsigned left;
    n = 0;
    left = q_clr.size() + q_en.size() + q_proc.size() + q_wr.size() + q_done.size();
    while (left != 0 && n < budget) begin
      @(posedge clk);
      n++;
      left = q_clr.size() + q_en.size() + q_proc.size() + q_wr.size() + q_done.size();
    end
    #1;
    check(name, left, 0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_clr"}, 32'(consumer_clr), 0);
    check({name, "_en"}, 32'(enable), 0);
    check({name, "_proc"}, 32'(enable_process), 0);
    check({name, "_wr_en"}, 32'(wr_en), 0);
    check({name, "_done"}, 32'(done), 0);
    check({name, "_mem_addr"}, 32'(mem_addr), 0);
    check({name, "_wr_addr"}, 32'(wr_addr), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned s;
    int unsigned d0;
    total    = 0;
    bad      = 0;
    edge_cnt = 0;
    done_cnt = 0;
    rom_mode = 0;
    add_val  = 8'd5;
    rst      = 1'b1;
    start    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Small frame timing: writes 15..26, done at cycle 27.
    issue_start(s);
    push_frame(s, 0, 8'd5, 999);
    drain("t1_drain", 60);
    repeat (3) @(posedge clk);
    #1;
    check_quiet("t1_idle");

    // Saturation: every result clips to 0xFF; clear only in cycle 1.
    rom_mode = 1;
    add_val  = 8'h20;
    issue_start(s);
    push_frame(s, 1, 8'h20, 999);
    drain("t2_drain", 60);
    repeat (3) @(posedge clk);
    #1;

    // start during the frame is ignored.
    rom_mode = 0;
    add_val  = 8'd5;
    d0 = done_cnt;
    issue_start(s);
    push_frame(s, 0, 8'd5, 999);
    repeat (7) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain("t3_drain", 60);
    repeat (30) @(posedge clk);
    #1;
    check("t3_done_count", done_cnt - d0, 1);
    check_quiet("t3_idle");

    // Back-to-back: second CLEAR in the cycle after done, wr_addr restarts at 0.
    start = 1'b1;
    s = edge_cnt + 1;
    push_frame(s, 0, 8'd5, 999);
    push_frame(s + 2 * N + 3, 0, 8'd5, 999);
    repeat (2 * N + 4) @(posedge clk);
    #1;
    start = 1'b0;
    drain("t4_drain", 80);
    repeat (5) @(posedge clk);
    #1;
    check_quiet("t4_idle");

    // Mid-frame reset in cycle 16, then a clean frame.
    d0 = done_cnt;
    issue_start(s);
    push_frame(s, 0, 8'd5, 15);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_quiet("t5_rst");
    check("t5_consumed", q_clr.size() + q_en.size() + q_proc.size() + q_wr.size(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("t5_no_done", done_cnt - d0, 0);
    issue_start(s);
    push_frame(s, 0, 8'd5, 999);
    drain("t5_drain", 60);
    repeat (3) @(posedge clk);
    #1;
    check_quiet("t5_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_streamer.md
# frame_streamer

Frame sequencer for the lab 3 pixel pipeline. It drives the frame-buffered pixel consumer (the brightness-style filter block) from the sending side. It reads one frame from a synchronous pixel ROM and streams it into the consumer with `enable`, then clocks the consumer through processing with `enable_process`. Each processed pixel returning on `image_output` is written to a result RAM. It sits between the image ROM, the filter, and the result memory, and owns the whole per-frame handshake.

## Interface
- `WIDTH`, 361, pixels per row
- `DEPTH`, 410, rows per frame
- `PIX_W`, 8, pixel width
- `ADDR_W`, 18, address width; must satisfy 2^ADDR_W ≥ WIDTH*DEPTH
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: begin one frame; sampled only in IDLE
- `mem_addr` out ADDR_W: ROM read address; ROM data returns the next cycle
- `mem_data` in PIX_W: ROM read data
- `consumer_clr` out 1: one-cycle clear to the consumer's `rst`
- `image_input` out PIX_W: pixel to consumer; combinational copy of `mem_data`
- `enable` out 1: consumer load strobe
- `enable_process` out 1: consumer process strobe
- `image_output` in PIX_W: processed pixel from consumer
- `wr_en` out 1: result RAM write strobe
- `wr_addr` out ADDR_W: result RAM address
- `wr_data` out PIX_W: equals `image_output`
- `busy` out 1: frame in progress
- `done` out 1: one-cycle pulse at frame completion

## Operation
- N = WIDTH*DEPTH.
- States: IDLE, CLEAR, LOAD, PROCESS, FLUSH.
- **IDLE**
  - All strobes low; `mem_addr`=0; `wr_addr`=0.
  - `start`=1 → CLEAR.
- **CLEAR** (1 cycle)
  - `consumer_clr`=1; `mem_addr`=0 is issued.
  - → LOAD.
- **LOAD**
  - Read counter issues addresses 1..N-1, one per cycle.
  - `enable`=1 on every cycle that ROM data returns, which is exactly N cycles.
  - `image_input` = `mem_data`.
  - After the N-th `enable` cycle → PROCESS.
- **PROCESS**
  - `enable_process`=1 for exactly N cycles, counted by the process counter.
  - Then → FLUSH.
- **Result capture**
  - `wr_en` is `enable_process` delayed one cycle; the consumer result is valid one cycle after its process strobe.
  - `wr_addr` starts at 0 and increments after each write.
- **FLUSH** (1 cycle)
  - Performs the last write.
  - → IDLE; `done` is pulsed in the first IDLE cycle.
- **Strobe rules**
  - `enable` and `enable_process` are never high in the same cycle.
  - `consumer_clr` never coincides with either strobe.
- **Boundary conditions**
  - `start` while `busy` is ignored; it is neither queued nor restarts the frame.
  - `start` held high continuously starts a new frame in the first IDLE cycle after `done`, so `done` and the next CLEAR are one cycle apart.
  - Counters compare against N-1 and never wrap past it. `mem_addr` holds at N-1 after the last read issue.
  - `rst` mid-frame returns to IDLE immediately. No `done` is produced and no further `wr_en` is issued.
- **Reset values:** all outputs 0; state IDLE.

## Timing
- Cycle k means the cycle after rising edge k; `start` is sampled high at edge 1.
- Cycle 1: CLEAR, `consumer_clr`=1, `mem_addr`=0.
- Cycles 2..N+1: `enable`=1. `mem_addr` = k-1 in cycles 2..N.
- Cycles N+2..2N+1: `enable_process`=1.
- Cycles N+3..2N+2: `wr_en`=1, with `wr_addr` = k-(N+3).
- Cycle 2N+3: `done`=1.
- `busy`=1 in cycles 1..2N+2.
- Total frame latency: 2N+3 cycles from `start`.
- Throughput: one pixel per cycle in each phase.

## Structure
- **Package `frame_pkg`:**
  - Default `WIDTH`/`DEPTH`.
  - Function deriving N and `ADDR_W`.
  - State enum `frame_state_t` {IDLE, CLEAR, LOAD, PROCESS, FLUSH}.
- **Sub-module `frame_addr_counter`:**
  - Parameterised ADDR_W up-counter with clear, increment and terminal-count (== N-1) flag.
  - Instantiated three times: read, process and write counters.
- FSM and capture register live in the top.

## Test plan
- **Small frame timing.** WIDTH=4, DEPTH=3 (N=12), ROM[i]=i+10, ideal brightness model with +5 saturate.
  - Required: `enable` cycles 2–13 carrying 10..21; `enable_process` 14–25.
  - Writes 15..26 to addresses 0..11 with data 15..26; `done` at cycle 27.
- **Saturation passthrough.** ROM all 0xF0, consumer add 0x20.
  - Required: all 12 writes carry 0xFF.
  - Required: `consumer_clr` asserted only in cycle 1.
- **`start` while busy.** `start` pulsed again at cycle 8.
  - Required: no restart; exactly 12 writes and one `done`.
- **Back-to-back frames.** `start` held high.
  - Required: second CLEAR in the cycle after `done`; `wr_addr` restarts at 0.
- **Mid-frame reset.** `rst` asserted at cycle 16.
  - Required: all outputs 0 the same cycle; no `done`; the next `start` runs a clean 27-cycle frame.
- **Default-size smoke run.** N=148010.
  - Required: `done` at cycle 296023.
  - Required: `enable` and `enable_process` never both high.
